phrase_display_driver: RTL and testbench

//  Consumes the 80-bit, 16-character phrase (5-bit char codes, char 0 = bits [79:75]) built by the greetings stage.

---
 rtl/greet_pkg.sv | 81 ++++++++
 rtl/seg_scan.sv | 35 +++
 rtl/phrase_display_driver.sv | 116 +++++++++++
 tb/tb_phrase_display_driver.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/greet_pkg.sv
// rtl/greet_pkg.sv - shared 5-bit character codes and the character-to-segment decode used by the greetings path.
package greet_pkg;

    localparam int NUM_CHARS  = 16;
    localparam int NUM_DIGITS = 8;

    localparam logic [4:0] CHAR_O     = 5'b00000;
    localparam logic [4:0] CHAR_1     = 5'b00001;
    localparam logic [4:0] CHAR_2     = 5'b00010;
    localparam logic [4:0] CHAR_3     = 5'b00011;
    localparam logic [4:0] CHAR_4     = 5'b00100;
    localparam logic [4:0] CHAR_5     = 5'b00101;
    localparam logic [4:0] CHAR_6     = 5'b00110;
    localparam logic [4:0] CHAR_7     = 5'b00111;
    localparam logic [4:0] CHAR_8     = 5'b01000;
    localparam logic [4:0] CHAR_9     = 5'b01001;
    localparam logic [4:0] CHAR_A     = 5'b01010;
    localparam logic [4:0] CHAR_B     = 5'b01011;
    localparam logic [4:0] CHAR_C     = 5'b01100;
    localparam logic [4:0] CHAR_D     = 5'b01101;
    localparam logic [4:0] CHAR_E     = 5'b01110;
    localparam logic [4:0] CHAR_F     = 5'b01111;
    localparam logic [4:0] CHAR_G     = 5'b10000;
    localparam logic [4:0] CHAR_H     = 5'b10001;
    localparam logic [4:0] CHAR_I     = 5'b10010;
    localparam logic [4:0] CHAR_J     = 5'b10011;
    localparam logic [4:0] CHAR_L     = 5'b10100;
    localparam logic [4:0] CHAR_N     = 5'b10101;
    localparam logic [4:0] CHAR_P     = 5'b10110;
    localparam logic [4:0] CHAR_R     = 5'b10111;
    localparam logic [4:0] CHAR_S     = 5'b11000;
    localparam logic [4:0] CHAR_T     = 5'b11001;
    localparam logic [4:0] CHAR_U     = 5'b11010;
    localparam logic [4:0] CHAR_Y     = 5'b11011;
    localparam logic [4:0] CHAR_DASH  = 5'b11100;
    localparam logic [4:0] CHAR_BLANK = 5'b11111;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        PG_HI = 1'b0,
        PG_LO = 1'b1
    } page_state_t;

    // Segments are {g,f,e,d,c,b,a}, active-low; unlisted codes stay dark.
    function automatic logic [6:0] char_to_seg(input logic [4:0] code);
        case (code)
            CHAR_O:    return 7'h40;
            CHAR_1:    return 7'h79;
            CHAR_2:    return 7'h24;
            CHAR_3:    return 7'h30;
            CHAR_4:    return 7'h19;
            CHAR_5:    return 7'h12;
            CHAR_6:    return 7'h02;
            CHAR_7:    return 7'h78;
            CHAR_8:    return 7'h00;
            CHAR_9:    return 7'h10;
            CHAR_A:    return 7'h08;
            CHAR_B:    return 7'h03;
            CHAR_C:    return 7'h46;
            CHAR_D:    return 7'h21;
            CHAR_E:    return 7'h06;
            CHAR_F:    return 7'h0E;
            CHAR_G:    return 7'h42;
            CHAR_H:    return 7'h09;
            CHAR_I:    return 7'h79;
            CHAR_J:    return 7'h61;
            CHAR_L:    return 7'h47;
            CHAR_N:    return 7'h2B;
            CHAR_P:    return 7'h0C;
            CHAR_R:    return 7'h2F;
            CHAR_S:    return 7'h12;
            CHAR_T:    return 7'h07;
            CHAR_U:    return 7'h41;
            CHAR_Y:    return 7'h11;
            CHAR_DASH: return 7'h3F;
            default:   return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - digit slot counter and registered active-low anode drive for the 8-digit display.
module seg_scan
    import greet_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] an,
    output logic [2:0] digit
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

    logic [SW-1:0] slot;

    // The anode register follows the digit index by one cycle, matching the seg register in the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot  <= '0;
            digit <= '0;
            an    <= 8'hFF;
        end else begin
            if (slot == SLOT_LAST) begin
                slot  <= '0;
                digit <= digit + 3'd1;
            end else begin
                slot <= slot + 1'b1;
            end
            an <= ~(8'b1 << digit);
        end
    end

endmodule

// File: rtl/phrase_display_driver.sv
// rtl/phrase_display_driver.sv - shows a 16-char phrase on an 8-digit 7-seg display as two pages, or a scrolling window when SCROLL_EN is defined.
module phrase_display_driver
    import greet_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,
    parameter int PAGE_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [79:0] phrase_in,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  page
);

    localparam int PW = (PAGE_DIV > 1) ? $clog2(PAGE_DIV) : 1;
    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGE_DIV - 1);

    logic [79:0]   phrase_q;
    logic          capture;
    logic [PW-1:0] page_cnt;
    logic          page_tick;
    logic [2:0]    digit;
    logic [3:0]    char_idx;
    logic [4:0]    chars [NUM_CHARS];

    assign capture   = (phrase_in != phrase_q);
    assign page_tick = (page_cnt == PAGE_LAST);
    assign dp        = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            phrase_q <= {NUM_CHARS{CHAR_BLANK}};
        end else if (capture) begin
            phrase_q <= phrase_in;
        end
    end

    // A new phrase restarts the page timing so it is always first seen from char 0.
    always_ff @(posedge clk) begin
        if (reset || capture || page_tick) begin
            page_cnt <= '0;
        end else begin
            page_cnt <= page_cnt + 1'b1;
        end
    end

`ifdef SCROLL_EN
    logic [3:0] start_idx;

    always_ff @(posedge clk) begin
        if (reset || capture) begin
            start_idx <= 4'd0;
        end else if (page_tick) begin
            start_idx <= start_idx + 4'd1;
        end
    end

    assign page = start_idx;
`else
    page_state_t state_q;
    page_state_t state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PG_HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (capture) begin
            state_d = PG_HI;
        end else if (page_tick) begin
            state_d = (state_q == PG_HI) ? PG_LO : PG_HI;
        end
    end

    always_comb begin
        page = 4'd0;
        if (state_q == PG_LO) begin
            page = 4'd8;
        end
    end
`endif

    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .an    (an),
        .digit (digit)
    );

    always_comb begin
        for (int i = 0; i < NUM_CHARS; i++) begin
            chars[i] = phrase_q[79 - 5*i -: 5];
        end
    end

    // Leftmost digit (d=7) shows the window start; 4-bit arithmetic gives the mod-16 wrap.
    assign char_idx = page + 4'd7 - {1'b0, digit};

    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= SEG_BLANK;
        end else begin
            seg <= char_to_seg(chars[char_idx]);
        end
    end

endmodule

// File: tb/tb_phrase_display_driver.sv
// tb/tb_phrase_display_driver.sv - directed self-checking bench for phrase_display_driver (SCAN_DIV=4, PAGE_DIV=64).
module tb_phrase_display_driver;

    localparam int SCAN_DIV = 4;
    localparam int PAGE_DIV = 64;

    localparam logic [4:0] C_O  = 5'b00000;
    localparam logic [4:0] C_H  = 5'b10001;
    localparam logic [4:0] C_E  = 5'b01110;
    localparam logic [4:0] C_L  = 5'b10100;
    localparam logic [4:0] C_BL = 5'b11111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [79:0] phrase_in;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  page;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run;
    logic [4:0] ph [16];

    phrase_display_driver #(
        .SCAN_DIV (SCAN_DIV),
        .PAGE_DIV (PAGE_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .phrase_in (phrase_in),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .page      (page)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    function automatic logic [6:0] exp_seg(input logic [4:0] c);
        case (c)
            5'b00000: return 7'h40;
            5'b10001: return 7'h09;
            5'b01110: return 7'h06;
            5'b10100: return 7'h47;
            default:  return 7'h7F;
        endcase
    endfunction

    function automatic logic [3:0] exp_page(input int ticks);
`ifdef SCROLL_EN
        return 4'(ticks % 16);
`else
        return (ticks % 2 == 1) ? 4'd8 : 4'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic set_phrase();
        for (int i = 0; i < 16; i++) phrase_in[79 - 5*i -: 5] = ph[i];
        cyc = 0;
    endtask

    task automatic scan_check(input string tag, input int n, input logic [3:0] pg);
        int k;
        int zeros;
        logic [3:0] idx;
        for (int i = 0; i < n; i++) begin
            tick();
            k = 0;
            zeros = 0;
            for (int b = 0; b < 8; b++) begin
                if (!an[b]) begin
                    zeros++;
                    k = b;
                end
            end
            check({tag, " onehot"}, 32'(zeros), 32'd1);
            idx = pg + 4'd7 - 4'(k);
            check({tag, " seg"}, 32'(seg), 32'(exp_seg(ph[idx])));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ph[i] = C_BL;
        set_phrase();
        reset = 1'b1;

        // 1: reset state and first anode after release
        repeat (3) @(negedge clk);
        check("rst an", 32'(an), 32'hFF);
        check("rst seg", 32'(seg), 32'h7F);
        check("rst dp", 32'(dp), 32'd1);
        check("rst page", 32'(page), 32'd0);
        reset = 1'b0;
        tick();
        check("first an", 32'(an), 32'hFE);
        check("first seg", 32'(seg), 32'h7F);
        run = 1;
        while (an == 8'hFE && run < 10) begin
            tick();
            if (an == 8'hFE) run++;
        end
        check("digit hold", 32'(run), 32'd4);

        // 2: HELLO on page 0
        ph[1] = C_H; ph[2] = C_E; ph[3] = C_L; ph[4] = C_L; ph[5] = C_O;
        set_phrase();
        tick();
        scan_check("hello pg0", 32, 4'd0);
        check("hello page", 32'(page), 32'd0);

        // 3: page alternation
        wait_cyc(64);
        check("pre tick page", 32'(page), 32'(exp_page(0)));
        tick();
        check("tick1 page", 32'(page), 32'(exp_page(1)));
        tick();
        scan_check("hello pg1", 24, exp_page(1));
        wait_cyc(128);
        check("pre tick2 page", 32'(page), 32'(exp_page(1)));
        tick();
        check("tick2 page", 32'(page), 32'(exp_page(2)));

        // 4: capture on the same edge as a page tick
        wait_cyc(192);
        ph[0] = C_H;  ph[1] = C_E;  ph[2] = C_L;  ph[3] = C_L;
        ph[4] = C_O;  ph[5] = C_BL; ph[6] = C_BL; ph[7] = C_BL;
        ph[8] = C_O;  ph[9] = C_L;  ph[10] = C_E; ph[11] = C_H;
        ph[12] = C_BL; ph[13] = C_BL; ph[14] = C_BL; ph[15] = C_E;
        set_phrase();
        tick();
        check("capture wins page", 32'(page), 32'd0);
        wait_cyc(64);
        check("cap pre tick page", 32'(page), 32'd0);
        tick();
        check("cap tick page", 32'(page), 32'(exp_page(1)));
        tick();
        scan_check("phrase2 pg1", 24, exp_page(1));

        // 5: reset mid-scan on the second page
        run = 0;
        while (an != 8'hDF && run < 40) begin
            tick();
            run++;
        end
        check("found digit5", 32'(an), 32'hDF);
        check("mid page", 32'(page), 32'(exp_page(1)));
        reset = 1'b1;
        tick();
        check("mid rst an", 32'(an), 32'hFF);
        check("mid rst seg", 32'(seg), 32'h7F);
        check("mid rst dp", 32'(dp), 32'd1);
        check("mid rst page", 32'(page), 32'd0);
        check("mid rst phrase", 32'(dut.phrase_q == {16{C_BL}}), 32'd1);
        reset = 1'b0;
        tick();
        check("post rst an", 32'(an), 32'hFE);

`ifdef SCROLL_EN
        // 6: scrolling window wraps through 16 start positions
        ph[0] = C_O;  ph[1] = C_BL; ph[2] = C_L;  ph[3] = C_BL;
        ph[4] = C_E;  ph[5] = C_H;  ph[6] = C_O;  ph[7] = C_L;
        ph[8] = C_BL; ph[9] = C_E;  ph[10] = C_O; ph[11] = C_L;
        ph[12] = C_BL; ph[13] = C_H; ph[14] = C_E; ph[15] = C_O;
        set_phrase();
        wait_cyc(13 * 64 + 1);
        check("scroll page13", 32'(page), 32'd13);
        tick();
        scan_check("scroll 13", 32, 4'd13);
        wait_cyc(16 * 64 + 1);
        check("scroll wrap page", 32'(page), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
